// File: rtl/decode_pkg.sv
// Shared decode definitions: control-bundle layout, branch encodings, bubble value.
package decode_pkg;

  localparam int unsigned CTRL_W = 15;

  // Bit positions inside the packed control bundle (MSB to LSB)
  localparam int unsigned CTRL_REG_WRITE     = 14;
  localparam int unsigned CTRL_ALU_SRC       = 13;
  localparam int unsigned CTRL_MEM_WRITE     = 12;
  localparam int unsigned CTRL_RESULT_SRC_HI = 11;
  localparam int unsigned CTRL_RESULT_SRC_LO = 10;
  localparam int unsigned CTRL_JUMP          = 9;
  localparam int unsigned CTRL_BRANCH_HI     = 8;
  localparam int unsigned CTRL_BRANCH_LO     = 6;
  localparam int unsigned CTRL_ALU_CTL_HI    = 5;
  localparam int unsigned CTRL_ALU_CTL_LO    = 2;
  localparam int unsigned CTRL_ALU_SRC_A     = 1;
  localparam int unsigned CTRL_PC_TGT_SRC    = 0;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } branch_e;

  // All-zero bundle: no register write, no memory write, no jump, no branch
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 15'd0;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       jump;
    branch_e    branch;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic       pc_target_src;
  } ctrl_t;

  // Flatten a control struct into the bundle layout used on the pipeline ports
  function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_t c);
    return CTRL_W'(c);
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register: async reset, synchronous clear (priority), enable.
module pipe_reg_en_clr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear beats enable so a flush overrides a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble, validity and bubble counter.
module decode_execute_reg
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CNT_W-1:0]  BubbleCount
);

  localparam int unsigned DATA_W = 5 * XLEN;
  localparam int unsigned IDX_W  = 15;

  logic              bubble_c;
  logic              load_en_c;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  bubble_cnt;

  // Flush wins over stall; an invalid D slot becomes a bubble only when not stalled
  always_comb begin
    bubble_c  = FlushE | (~StallE & ~ValidD);
    load_en_c = ~StallE;
  end

  pipe_reg_en_clr #(.W(1)) u_valid (
    .clk (clk),
    .rst (rst),
    .en  (load_en_c),
    .clr (bubble_c),
    .d   (1'b1),
    .q   (ValidE)
  );

  pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (load_en_c),
    .clr (bubble_c),
    .d   (CtrlD),
    .q   (CtrlE)
  );

  pipe_reg_en_clr #(.W(DATA_W)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (load_en_c),
    .clr (bubble_c),
    .d   ({RD1D, RD2D, PCD, ImmExtD, PCPlus4D}),
    .q   (data_q)
  );

  // Zeroed indices keep forwarding comparators from ever matching a bubble
  pipe_reg_en_clr #(.W(IDX_W)) u_idx (
    .clk (clk),
    .rst (rst),
    .en  (load_en_c),
    .clr (bubble_c),
    .d   ({Rs1D, Rs2D, RdD}),
    .q   (idx_q)
  );

  // Free-running bubble counter, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_c) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Unpack registered groups onto the E-stage ports
  always_comb begin
    {RD1E, RD2E, PCE, ImmExtE, PCPlus4E} = data_q;
    {Rs1E, Rs2E, RdE}                    = idx_q;
    BubbleCount                          = bubble_cnt;
  end

endmodule
